counter_gray_src: RTL and testbench

//  Up/down event counter in the source (din) clock domain. Produces a registered

---
 rtl/counter_gray_src_pkg.sv | 24 ++
 rtl/counter_gray_src_bin2gray.sv | 17 +
 rtl/counter_gray_src.sv | 68 ++++++
 tb/tb_counter_gray_src.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/counter_gray_src_pkg.sv
// rtl/counter_gray_src_pkg.sv - shared Gray/binary helpers and count-limit derivation
// Used by counter_gray_src and by the downstream gray-to-binary stage.
package counter_gray_src_pkg;

  localparam int DEF_BUS_WIDTH = 4;

  function automatic logic [31:0] max_count(input int width);
    return 32'hffff_ffff >> (32 - width);
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/counter_gray_src_bin2gray.sv
// rtl/counter_gray_src_bin2gray.sv - combinational binary-to-Gray converter
// Sits in front of the Gray register so the registered output has no logic after it.
module counter_bin2gray
  import counter_gray_src_pkg::*;
#(
  parameter int BUS_WIDTH = DEF_BUS_WIDTH
) (
  input  logic [BUS_WIDTH-1:0] bin,
  output logic [BUS_WIDTH-1:0] gray
);

  logic [31:0] gray_wide;

  assign gray_wide = bin2gray(32'(bin));
  assign gray      = gray_wide[BUS_WIDTH-1:0];

endmodule

// File: rtl/counter_gray_src.sv
// rtl/counter_gray_src.sv - up/down event counter with registered Gray output for per-bit sync
// Define COUNTER_GRAY_SAT_EN to saturate at the limits instead of wrapping.
module counter_gray_src
  import counter_gray_src_pkg::*;
#(
  parameter int BUS_WIDTH = DEF_BUS_WIDTH
) (
  input  logic                 i_clk_din,
  input  logic                 i_rstn_din,
  input  logic                 i_en,
  input  logic                 i_up,
  input  logic                 i_clr,
  output logic [BUS_WIDTH-1:0] o_bin_cnt,
  output logic [BUS_WIDTH-1:0] o_gray_cnt,
  output logic                 o_wrap
);

  localparam logic [31:0]          MAX_WIDE = max_count(BUS_WIDTH);
  localparam logic [BUS_WIDTH-1:0] MAX      = MAX_WIDE[BUS_WIDTH-1:0];

  logic [BUS_WIDTH-1:0] bin_q;
  logic [BUS_WIDTH-1:0] gray_q;
  logic                 wrap_q;
  logic                 at_limit;
  logic [BUS_WIDTH-1:0] nxt_bin;
  logic [BUS_WIDTH-1:0] step_bin;
  logic [BUS_WIDTH-1:0] step_gray;

  assign at_limit = i_up ? (bin_q == MAX) : (bin_q == '0);
  assign nxt_bin  = i_up ? bin_q + 1'b1 : bin_q - 1'b1;

`ifdef COUNTER_GRAY_SAT_EN
  // A blocked step leaves both registers unchanged, so the Gray output cannot move.
  assign step_bin = at_limit ? bin_q : nxt_bin;
`else
  assign step_bin = nxt_bin;
`endif

  counter_bin2gray #(
    .BUS_WIDTH(BUS_WIDTH)
  ) u_bin2gray (
    .bin  (step_bin),
    .gray (step_gray)
  );

  always_ff @(posedge i_clk_din or negedge i_rstn_din) begin
    if (!i_rstn_din) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else if (i_clr) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else if (i_en) begin
      bin_q  <= step_bin;
      gray_q <= step_gray;
      wrap_q <= at_limit;
    end else begin
      wrap_q <= 1'b0;
    end
  end

  assign o_bin_cnt  = bin_q;
  assign o_gray_cnt = gray_q;
  assign o_wrap     = wrap_q;

endmodule

// File: tb/tb_counter_gray_src.sv
// tb/tb_counter_gray_src.sv - directed self-checking bench for counter_gray_src (BUS_WIDTH=4)
// Covers both builds: expectations follow COUNTER_GRAY_SAT_EN.
module tb_counter_gray_src;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       up;
  logic       clr;
  logic [3:0] bin_cnt;
  logic [3:0] gray_cnt;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  counter_gray_src #(
    .BUS_WIDTH(4)
  ) dut (
    .i_clk_din  (clk),
    .i_rstn_din (rst_n),
    .i_en       (en),
    .i_up       (up),
    .i_clr      (clr),
    .o_bin_cnt  (bin_cnt),
    .o_gray_cnt (gray_cnt),
    .o_wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
  task automatic step(input logic s_en, input logic s_up, input logic s_clr);
    @(negedge clk);
    en  = s_en;
    up  = s_up;
    clr = s_clr;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_and_count(input int n);
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0);
  endtask

  logic [3:0] gray_tbl [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                4'b0111, 4'b0101, 4'b0100, 4'b1100,
                                4'b1101, 4'b1111, 4'b1110, 4'b1010,
                                4'b1011, 4'b1001, 4'b1000, 4'b0000};

  initial begin
    logic [3:0] prev_gray;
    rst_n = 1'b0;
    en    = 1'b0;
    up    = 1'b1;
    clr   = 1'b0;

    // 1: reset and first count
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_bin", bin_cnt, 0);
    check_val("rst_gray", gray_cnt, 0);
    check_val("rst_wrap", wrap, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    check_val("t1_bin", bin_cnt, 1);
    check_val("t1_gray", gray_cnt, 4'b0001);
    check_val("t1_wrap", wrap, 0);

    // hold with en low
    step(1'b0, 1'b1, 1'b0);
    check_val("hold_bin", bin_cnt, 1);
    check_val("hold_wrap", wrap, 0);

    // 2: full cycle up from 0
    clear_and_count(0);
    prev_gray = gray_cnt;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 1'b0);
      check_val($sformatf("t2_bin%0d", i), bin_cnt, (i + 1) % 16);
      check_val($sformatf("t2_gray%0d", i), gray_cnt, gray_tbl[i]);
      check_val($sformatf("t2_wrap%0d", i), wrap, (i == 15) ? 1 : 0);
      check_val($sformatf("t2_ham%0d", i), ($countones(prev_gray ^ gray_cnt) <= 1) ? 1 : 0, 1);
      prev_gray = gray_cnt;
    end

    // 3: down from 0
    clear_and_count(0);
    step(1'b1, 1'b0, 1'b0);
`ifdef COUNTER_GRAY_SAT_EN
    check_val("t3_bin", bin_cnt, 0);
    check_val("t3_gray", gray_cnt, 4'b0000);
`else
    check_val("t3_bin", bin_cnt, 15);
    check_val("t3_gray", gray_cnt, 4'b1000);
`endif
    check_val("t3_wrap", wrap, 1);
    step(1'b0, 1'b0, 1'b0);
    check_val("t3_wrap_drop", wrap, 0);

    // direction change: still one Gray bit per step
    clear_and_count(5);
    prev_gray = gray_cnt;
    step(1'b1, 1'b0, 1'b0);
    check_val("dir_bin", bin_cnt, 4);
    check_val("dir_ham", ($countones(prev_gray ^ gray_cnt) <= 1) ? 1 : 0, 1);
    check_val("dir_gray", gray_cnt, 4'b0110);

    // 4: clear overrides enable
    clear_and_count(7);
    check_val("t4_pre_bin", bin_cnt, 7);
    step(1'b1, 1'b1, 1'b1);
    check_val("t4_bin", bin_cnt, 0);
    check_val("t4_gray", gray_cnt, 0);
    check_val("t4_wrap", wrap, 0);

    // 5: asynchronous reset between edges
    clear_and_count(9);
    check_val("t5_pre_bin", bin_cnt, 9);
    @(negedge clk);
    en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("t5_bin", bin_cnt, 0);
    check_val("t5_gray", gray_cnt, 0);
    check_val("t5_wrap", wrap, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    check_val("t5_resume", bin_cnt, 1);

    // 6: step past MAX twice
    clear_and_count(15);
    check_val("t6_pre_bin", bin_cnt, 15);
    step(1'b1, 1'b1, 1'b0);
`ifdef COUNTER_GRAY_SAT_EN
    check_val("t6_bin_a", bin_cnt, 15);
    check_val("t6_gray_a", gray_cnt, 4'b1000);
    check_val("t6_wrap_a", wrap, 1);
    step(1'b1, 1'b1, 1'b0);
    check_val("t6_bin_b", bin_cnt, 15);
    check_val("t6_gray_b", gray_cnt, 4'b1000);
    check_val("t6_wrap_b", wrap, 1);
`else
    check_val("t6_bin_a", bin_cnt, 0);
    check_val("t6_gray_a", gray_cnt, 4'b0000);
    check_val("t6_wrap_a", wrap, 1);
    step(1'b1, 1'b1, 1'b0);
    check_val("t6_bin_b", bin_cnt, 1);
    check_val("t6_gray_b", gray_cnt, 4'b0001);
    check_val("t6_wrap_b", wrap, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
